// File: rtl/mem_bus_arbiter.sv
// Two-to-one round-robin arbiter sharing one downstream memory port between
// the instruction-fetch bus and the data bus; one transaction in flight at a time.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [63:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_data,
  input  logic        cresp_ok,
  input  logic [63:0] cresp_data,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q;
  logic   last_d_q;  // 1 = data bus won the most recent grant
  logic   ia2_q;     // latched ireq_addr[2], selects the instruction half-word
  logic   pick_data;

  // Handshake: a requester holds valid until its data_ok pulse; addr_ok and
  // data_ok pulse together in RESP. Downstream: creq_valid is held with stable
  // fields until cresp_ok, which completes the transfer in that same cycle.
  assign pick_data   = dreq_valid && !(ireq_valid && last_d_q);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b0;
      ia2_q         <= 1'b0;
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      iresp_data    <= 32'd0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= 64'd0;
      creq_valid    <= 1'b0;
      creq_is_write <= 1'b0;
      creq_addr     <= 64'd0;
      creq_size     <= 3'd0;
      creq_strobe   <= 8'd0;
      creq_data     <= 64'd0;
    end else begin
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_data) begin
            creq_valid    <= 1'b1;
            creq_is_write <= |dreq_strobe;
            creq_addr     <= dreq_addr;
            creq_size     <= dreq_size;
            creq_strobe   <= dreq_strobe;
            creq_data     <= dreq_data;
            state_q       <= BUSY_D;
          end else if (ireq_valid) begin
            creq_valid    <= 1'b1;
            creq_is_write <= 1'b0;
            creq_addr     <= ireq_addr;
            creq_size     <= 3'b010;
            creq_strobe   <= 8'd0;
            creq_data     <= 64'd0;
            ia2_q         <= ireq_addr[2];
            state_q       <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (cresp_ok) begin
            creq_valid    <= 1'b0;
            iresp_addr_ok <= 1'b1;
            iresp_data_ok <= 1'b1;
            iresp_data    <= ia2_q ? cresp_data[63:32] : cresp_data[31:0];
            last_d_q      <= 1'b0;
            state_q       <= RESP;
          end
        end
        BUSY_D: begin
          if (cresp_ok) begin
            creq_valid    <= 1'b0;
            dresp_addr_ok <= 1'b1;
            dresp_data_ok <= 1'b1;
            dresp_data    <= cresp_data;
            last_d_q      <= 1'b1;
            state_q       <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single fetch, stalled write, contention,
// abandoned fetch and asynchronous reset in the middle of a data transaction.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic        creq_is_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ok;
  logic [63:0] cresp_data;
  logic [1:0]  dbg_state_o;

  int checks;
  int failures;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  mem_bus_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .creq_valid    (creq_valid),
    .creq_is_write (creq_is_write),
    .creq_addr     (creq_addr),
    .creq_size     (creq_size),
    .creq_strobe   (creq_strobe),
    .creq_data     (creq_data),
    .cresp_ok      (cresp_ok),
    .cresp_data    (cresp_data),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ireq_valid  = 1'b0;
    ireq_addr   = 64'd0;
    dreq_valid  = 1'b0;
    dreq_addr   = 64'd0;
    dreq_size   = 3'd0;
    dreq_strobe = 8'd0;
    dreq_data   = 64'd0;
    cresp_ok    = 1'b0;
    cresp_data  = 64'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  function automatic logic [63:0] all_outputs_or();
    return {63'd0, |{iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok,
                     dresp_data_ok, dresp_data, creq_valid, creq_is_write,
                     creq_addr, creq_size, creq_strobe, creq_data}};
  endfunction

  initial begin
    logic [63:0] exp_addr;
    logic        exp_i;
    checks   = 0;
    failures = 0;
    idle_inputs();
    apply_reset();

    // Reset state
    chk("reset_state", {62'd0, dbg_state_o}, {62'd0, S_IDLE});
    chk("reset_outputs", all_outputs_or(), 64'd0);

    // Single fetch, upper half-word selected by addr[2]
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0004;
    step();
    chk("fetch_creq_valid", {63'd0, creq_valid}, 64'd1);
    chk("fetch_creq_addr", creq_addr, 64'h8000_0004);
    chk("fetch_creq_size", {61'd0, creq_size}, 64'd2);
    chk("fetch_creq_is_write", {63'd0, creq_is_write}, 64'd0);
    chk("fetch_creq_strobe", {56'd0, creq_strobe}, 64'd0);
    cresp_ok   = 1'b1;
    cresp_data = 64'h1111_2222_3333_4444;
    step();
    cresp_ok   = 1'b0;
    ireq_valid = 1'b0;
    chk("fetch_data_ok", {63'd0, iresp_data_ok}, 64'd1);
    chk("fetch_addr_ok", {63'd0, iresp_addr_ok}, 64'd1);
    chk("fetch_data", {32'd0, iresp_data}, 64'h1111_2222);
    chk("fetch_no_dresp", {63'd0, dresp_data_ok}, 64'd0);
    chk("fetch_resp_creq_low", {63'd0, creq_valid}, 64'd0);
    step();
    chk("fetch_back_idle", {62'd0, dbg_state_o}, {62'd0, S_IDLE});
    chk("fetch_pulse_once", {63'd0, iresp_data_ok}, 64'd0);
    chk("fetch_data_hold", {32'd0, iresp_data}, 64'h1111_2222);

    // Data write with four downstream wait cycles
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_1000;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hF0;
    dreq_data   = 64'hAABB_CCDD_0000_0000;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 2) dreq_addr = 64'h0000_0BAD;
      chk("wr_creq_valid", {63'd0, creq_valid}, 64'd1);
      chk("wr_creq_is_write", {63'd0, creq_is_write}, 64'd1);
      chk("wr_creq_addr", creq_addr, 64'h8000_1000);
      chk("wr_creq_strobe", {56'd0, creq_strobe}, 64'hF0);
      chk("wr_creq_data", creq_data, 64'hAABB_CCDD_0000_0000);
      chk("wr_creq_size", {61'd0, creq_size}, 64'd3);
      chk("wr_no_dresp_yet", {63'd0, dresp_data_ok}, 64'd0);
    end
    cresp_ok   = 1'b1;
    cresp_data = 64'h0;
    step();
    cresp_ok   = 1'b0;
    dreq_valid = 1'b0;
    chk("wr_dresp_data_ok", {63'd0, dresp_data_ok}, 64'd1);
    chk("wr_dresp_addr_ok", {63'd0, dresp_addr_ok}, 64'd1);
    chk("wr_no_iresp", {63'd0, iresp_data_ok}, 64'd0);
    step();
    chk("wr_pulse_once", {63'd0, dresp_data_ok}, 64'd0);
    chk("wr_idle", {62'd0, dbg_state_o}, {62'd0, S_IDLE});

    // Contention from reset: expected grant order D, I, D, I
    ireq_valid  = 1'b1;
    ireq_addr   = 64'h0000_1000;
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h0000_2000;
    dreq_size   = 3'd3;
    dreq_strobe = 8'h00;
    dreq_data   = 64'd0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      exp_i    = (k % 2 == 1);
      exp_addr = exp_i ? 64'h0000_1000 : 64'h0000_2000;
      step();
      chk("arb_creq_valid", {63'd0, creq_valid}, 64'd1);
      chk("arb_grant_addr", creq_addr, exp_addr);
      chk("arb_busy_state", {62'd0, dbg_state_o}, {62'd0, exp_i ? S_BUSY_I : S_BUSY_D});
      cresp_ok   = 1'b1;
      cresp_data = {32'hC0DE_0000 + 32'(k), 32'hF00D_0000 + 32'(k)};
      step();
      cresp_ok = 1'b0;
      if (k == 3) begin
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
      end
      chk("arb_resp_state", {62'd0, dbg_state_o}, {62'd0, S_RESP});
      chk("arb_iresp_ok", {63'd0, iresp_data_ok}, {63'd0, exp_i});
      chk("arb_dresp_ok", {63'd0, dresp_data_ok}, {63'd0, !exp_i});
      chk("arb_no_overlap", {63'd0, iresp_data_ok & dresp_data_ok}, 64'd0);
      if (exp_i) chk("arb_idata", {32'd0, iresp_data}, {32'd0, 32'hF00D_0000 + 32'(k)});
      else       chk("arb_ddata", dresp_data, {32'hC0DE_0000 + 32'(k), 32'hF00D_0000 + 32'(k)});
      step();
      chk("arb_gap_idle", {62'd0, dbg_state_o}, {62'd0, S_IDLE});
      chk("arb_gap_no_reissue", {63'd0, creq_valid}, 64'd0);
      chk("arb_gap_no_pulse", {63'd0, iresp_data_ok | dresp_data_ok}, 64'd0);
    end

    // Fetch abandoned: valid drops and address changes after the grant
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0008;
    step();
    ireq_valid = 1'b0;
    ireq_addr  = 64'h0000_DEAD;
    chk("abn_creq_valid", {63'd0, creq_valid}, 64'd1);
    step();
    chk("abn_creq_held", {63'd0, creq_valid}, 64'd1);
    chk("abn_creq_addr", creq_addr, 64'h8000_0008);
    cresp_ok   = 1'b1;
    cresp_data = 64'h5555_6666_7777_8888;
    step();
    cresp_ok = 1'b0;
    chk("abn_data_ok", {63'd0, iresp_data_ok}, 64'd1);
    chk("abn_data", {32'd0, iresp_data}, 64'h7777_8888);
    step();
    chk("abn_pulse_once", {63'd0, iresp_data_ok}, 64'd0);
    step();
    chk("abn_stays_idle", {62'd0, dbg_state_o}, {62'd0, S_IDLE});
    chk("abn_no_creq", {63'd0, creq_valid}, 64'd0);

    // Asynchronous reset in the middle of BUSY_D
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_3000;
    dreq_size   = 3'd3;
    dreq_strobe = 8'h00;
    step();
    chk("rst_busy_d", {62'd0, dbg_state_o}, {62'd0, S_BUSY_D});
    #1 reset = 1'b0;
    #1;
    chk("rst_outputs_zero", all_outputs_or(), 64'd0);
    chk("rst_state_idle", {62'd0, dbg_state_o}, {62'd0, S_IDLE});
    dreq_valid = 1'b0;
    cresp_ok   = 1'b1;
    cresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    cresp_ok = 1'b0;
    chk("rst_held_zero", all_outputs_or(), 64'd0);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_after_idle", {62'd0, dbg_state_o}, {62'd0, S_IDLE});
      chk("rst_after_no_dresp", {63'd0, dresp_data_ok}, 64'd0);
      chk("rst_after_no_creq", {63'd0, creq_valid}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-to-one memory bus arbiter sharing a single downstream memory port between the fetch stage's instruction bus and the memory stage's data bus. Each requester sees a single-transaction handshake: hold valid until data_ok. The arbiter registers the winning request, drives it downstream until the memory acknowledges, then returns a one-cycle data_ok pulse with registered read data. On simultaneous requests, grant is round-robin so neither pipeline stage starves.

## Interface
- No parameters; all widths fixed (64-bit addresses and data).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- ireq_valid  in  1  fetch request pending; held until iresp_data_ok.
- ireq_addr  in  64  fetch address, 4-byte aligned.
- iresp_addr_ok  out  1  fetch request accepted; pulses together with iresp_data_ok.
- iresp_data_ok  out  1  one-cycle pulse: iresp_data valid.
- iresp_data  out  32  instruction word.
- dreq_valid  in  1  data request pending; held until dresp_data_ok.
- dreq_addr  in  64  data address.
- dreq_size  in  3  log2 byte count.
- dreq_strobe  in  8  byte enables; nonzero means write.
- dreq_data  in  64  write data, lane-aligned.
- dresp_addr_ok  out  1  data request accepted; pulses together with dresp_data_ok.
- dresp_data_ok  out  1  one-cycle pulse: dresp_data valid.
- dresp_data  out  64  read data (undefined for writes).
- creq_valid  out  1  downstream request.
- creq_is_write  out  1  1 = write.
- creq_addr  out  64  downstream address.
- creq_size  out  3  downstream size.
- creq_strobe  out  8  downstream byte enables.
- creq_data  out  64  downstream write data.
- cresp_ok  in  1  downstream completion; one cycle, while creq_valid is high.
- cresp_data  in  64  downstream read data, valid with cresp_ok.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Only dreq_valid set: latch the data request and go to BUSY_D.
  - Only ireq_valid set: latch the fetch request and go to BUSY_I.
  - Both set: grant the requester not granted last. The last-grant flag is I after reset, so the first tie goes to D.
  - Neither set: stay in IDLE.
- Latched fetch request:
  - creq_addr = ireq_addr, creq_size = 3'b010, creq_strobe = 0, creq_is_write = 0, creq_data = 0.
- Latched data request:
  - creq_is_write = |dreq_strobe; size, strobe, data and address are copied unchanged.
- BUSY_I / BUSY_D:
  - creq_valid = 1 and all creq_* fields are held stable from the latch.
  - On cresp_ok, capture cresp_data, record the owner, update the last-grant flag, and go to RESP.
- RESP:
  - The owner's addr_ok and data_ok are both 1 for exactly this cycle.
  - iresp_data = captured[63:32] when the latched ireq_addr[2]=1, else captured[31:0].
  - dresp_data = the full captured word.
  - Always go to IDLE next.
- Once latched, a transaction always completes, even if its requester drops valid or changes its address (for example, fetch redirect on a branch). data_ok still pulses and the requester discards the result.
- Requester inputs are ignored outside IDLE.
- The RESP→IDLE gap guarantees the requester has seen data_ok before re-arbitration, so a held valid is never issued twice.

## Timing
- Reset asserted, at any time including mid-transaction:
  - State → IDLE, last-grant → I.
  - All outputs 0: creq_*, iresp_*, dresp_* including data.
  - An in-flight downstream transaction is abandoned. Its late cresp_ok is ignored because creq_valid is 0.
- creq_* and *resp_* outputs are registered; no input reaches any output combinationally.
- Latency, with the request seen in IDLE at cycle 0:
  - creq_valid rises at cycle 1.
  - Earliest cresp_ok is at cycle 1.
  - data_ok is at cycle 2.
  - IDLE is at cycle 3, which is the earliest next grant.
- Minimum turnaround is 3 cycles per transaction. Each extra downstream wait cycle adds 1 cycle.
- iresp_data_ok and dresp_data_ok are never high in the same cycle.
- *resp_data holds its value after the pulse until the next RESP.

## Test plan
- Single fetch: ireq_addr=0x8000_0004, cresp_ok at cycle 1 with cresp_data=0x1111_2222_3333_4444.
  - creq_addr=0x8000_0004, size=2, is_write=0.
  - At cycle 2, iresp_data_ok=1 and iresp_data=0x1111_2222.
- Data write: dreq addr=0x8000_1000, strobe=0xF0, data=0xAABB_CCDD_0000_0000, cresp_ok delayed 4 cycles.
  - creq_* is held stable for 5 cycles with is_write=1.
  - dresp_data_ok pulses once.
- Contention: both valid continuously from reset for 4 transactions.
  - Grant order is D, I, D, I.
  - data_ok pulses never overlap.
  - No request is issued twice.
- Fetch abandoned: ireq_valid drops the cycle after the grant.
  - Transaction still completes and iresp_data_ok pulses once.
  - The next IDLE with no requests stays idle.
- Reset mid-BUSY_D: assert reset while creq_valid=1, then pulse cresp_ok during reset.
  - All outputs 0 immediately (asynchronous).
  - After release, state is IDLE and no dresp_data_ok occurs.
